// File: rtl/knn_load_sequencer.sv
// Streams training samples and the query vector from two synchronous memories into
// knn_system in MAX_ELEMENTS-wide bursts, then captures the final inferred class.
module knn_load_sequencer #(
    parameter int unsigned M            = 5,
    parameter int unsigned N            = 10,
    parameter int unsigned W            = 32,
    parameter int unsigned MAX_ELEMENTS = 16,
    parameter int unsigned TYPE_W       = 3,
    parameter int unsigned L            = 6,
    parameter int unsigned AW           = 12,
    localparam int unsigned IAW         = $clog2(M*N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic [AW-1:0]             tr_addr,
    output logic                      tr_rd_en,
    input  logic [W-1:0]              tr_rdata,
    output logic [IAW-1:0]            in_addr,
    output logic                      in_rd_en,
    input  logic [W-1:0]              in_rdata,
    output logic [W*MAX_ELEMENTS-1:0] training_data,
    output logic [TYPE_W-1:0]         training_data_type,
    output logic [W*MAX_ELEMENTS-1:0] input_data,
    output logic                      read_done,
    input  logic                      data_request,
    input  logic                      done,
    input  logic                      inference_done,
    input  logic [TYPE_W-1:0]         inferred_type,
    output logic [TYPE_W-1:0]         result_type,
    output logic                      result_valid
);

    localparam int unsigned ELEMS  = M * N;
    localparam int unsigned STRIDE = ELEMS + 1;
    localparam int unsigned NB     = (ELEMS + MAX_ELEMENTS - 1) / MAX_ELEMENTS;
    localparam int unsigned LAST_E = ELEMS - (NB - 1) * MAX_ELEMENTS;
    localparam int unsigned NSAMP  = 1 << L;
    localparam int unsigned SW     = L + 1;
    localparam int unsigned BW     = $clog2(NB) + 1;
    localparam int unsigned IW     = (MAX_ELEMENTS > 1) ? $clog2(MAX_ELEMENTS) : 1;

    typedef enum logic [3:0] {
        IDLE, FETCH, TYPE, DRAIN, SEND, WAIT_REQ, WAIT_DONE, WAIT_INF, REPORT
    } state_t;

    state_t          state;
    logic [SW-1:0]   sample;
    logic [BW-1:0]   burst;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   cap_idx;
    logic            cap_lane;
    logic            cap_lbl;
    logic [AW-1:0]   sample_base;
    logic [IAW-1:0]  elem_base;
    logic            req_flag;
    logic            done_flag;
    logic            inf_flag;

    logic            last_burst;
    logic [IW-1:0]   idx_last;
    logic [IAW-1:0]  next_elem_base;
    logic [AW-1:0]   next_sample_base;

    assign last_burst       = (burst == BW'(NB - 1));
    assign idx_last         = last_burst ? IW'(LAST_E - 1) : IW'(MAX_ELEMENTS - 1);
    assign next_elem_base   = elem_base + IAW'(MAX_ELEMENTS);
    assign next_sample_base = sample_base + AW'(STRIDE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= IDLE;
            busy               <= 1'b0;
            tr_addr            <= '0;
            tr_rd_en           <= 1'b0;
            in_addr            <= '0;
            in_rd_en           <= 1'b0;
            training_data      <= '0;
            training_data_type <= '0;
            input_data         <= '0;
            read_done          <= 1'b0;
            result_type        <= '0;
            result_valid       <= 1'b0;
            sample             <= '0;
            burst              <= '0;
            idx                <= '0;
            cap_idx            <= '0;
            cap_lane           <= 1'b0;
            cap_lbl            <= 1'b0;
            sample_base        <= '0;
            elem_base          <= '0;
            req_flag           <= 1'b0;
            done_flag          <= 1'b0;
            inf_flag           <= 1'b0;
        end else begin
            read_done    <= 1'b0;
            result_valid <= 1'b0;
            cap_lane     <= 1'b0;
            cap_lbl      <= 1'b0;

            // Memory data arrives one cycle after its read was issued.
            if (cap_lane) begin
                training_data[32'(cap_idx)*W +: W] <= tr_rdata;
                input_data[32'(cap_idx)*W +: W]    <= in_rdata;
            end
            if (cap_lbl) begin
                training_data_type <= tr_rdata[TYPE_W-1:0];
            end

            // Handshake pulses may land the cycle right after read_done, so remember them.
            if (state == WAIT_REQ || state == WAIT_DONE || state == WAIT_INF) begin
                if (data_request)   req_flag  <= 1'b1;
                if (done)           done_flag <= 1'b1;
                if (inference_done) inf_flag  <= 1'b1;
            end

            case (state)
                IDLE: begin
                    req_flag  <= 1'b0;
                    done_flag <= 1'b0;
                    inf_flag  <= 1'b0;
                    if (start) begin
                        busy          <= 1'b1;
                        sample        <= '0;
                        burst         <= '0;
                        sample_base   <= '0;
                        elem_base     <= '0;
                        idx           <= '0;
                        tr_addr       <= '0;
                        in_addr       <= '0;
                        tr_rd_en      <= 1'b1;
                        in_rd_en      <= 1'b1;
                        training_data <= '0;
                        input_data    <= '0;
                        state         <= FETCH;
                    end
                end
                FETCH: begin
                    cap_lane <= 1'b1;
                    cap_idx  <= idx;
                    if (idx == idx_last) begin
                        in_rd_en <= 1'b0;
                        if (last_burst) begin
                            tr_addr <= sample_base + AW'(ELEMS);
                            state   <= TYPE;
                        end else begin
                            tr_rd_en <= 1'b0;
                            state    <= DRAIN;
                        end
                    end else begin
                        idx     <= idx + IW'(1);
                        tr_addr <= tr_addr + AW'(1);
                        in_addr <= in_addr + IAW'(1);
                    end
                end
                TYPE: begin
                    tr_rd_en <= 1'b0;
                    cap_lbl  <= 1'b1;
                    state    <= DRAIN;
                end
                DRAIN: begin
                    read_done <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    req_flag  <= 1'b0;
                    done_flag <= 1'b0;
                    inf_flag  <= 1'b0;
                    state     <= last_burst ? WAIT_DONE : WAIT_REQ;
                end
                WAIT_REQ: begin
                    if (req_flag) begin
                        burst         <= burst + BW'(1);
                        elem_base     <= next_elem_base;
                        idx           <= '0;
                        tr_addr       <= sample_base + AW'(next_elem_base);
                        in_addr       <= next_elem_base;
                        tr_rd_en      <= 1'b1;
                        in_rd_en      <= 1'b1;
                        training_data <= '0;
                        input_data    <= '0;
                        state         <= FETCH;
                    end
                end
                WAIT_DONE: begin
                    // done takes priority; a request seen alongside it is dropped.
                    if (done_flag) begin
                        req_flag  <= 1'b0;
                        burst     <= '0;
                        elem_base <= '0;
                        if (sample == SW'(NSAMP - 1)) begin
                            state <= WAIT_INF;
                        end else begin
                            sample        <= sample + SW'(1);
                            sample_base   <= next_sample_base;
                            idx           <= '0;
                            tr_addr       <= next_sample_base;
                            in_addr       <= '0;
                            tr_rd_en      <= 1'b1;
                            in_rd_en      <= 1'b1;
                            training_data <= '0;
                            input_data    <= '0;
                            state         <= FETCH;
                        end
                    end
                end
                WAIT_INF: begin
                    if (inf_flag) begin
                        result_type  <= inferred_type;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= REPORT;
                    end
                end
                REPORT: begin
                    req_flag  <= 1'b0;
                    done_flag <= 1'b0;
                    inf_flag  <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knn_load_sequencer.sv
// Scoreboard bench for knn_load_sequencer: full 64-sample run with handshake corner
// cases, mid-run abort, and a small single-burst configuration.
module tb_knn_load_sequencer;

    localparam int unsigned BUSW = 512;

    typedef struct {
        logic [11:0]     addr;
        logic [BUSW-1:0] td;
        logic [BUSW-1:0] id;
        logic [2:0]      typ;
        int              lat;
        int              trn;
        int              inn;
    } exp_t;

    logic clk;
    logic rst;
    logic start;
    logic sel;
    logic data_request, done, inference_done;
    logic [2:0]  inferred_type;
    logic [31:0] tr_rdata, in_rdata;

    logic            start1, busy1, tr_rd_en1, in_rd_en1, read_done1, result_valid1;
    logic [11:0]     tr_addr1;
    logic [5:0]      in_addr1;
    logic [BUSW-1:0] td1, id1;
    logic [2:0]      type1, result_type1;

    logic            start2, busy2, tr_rd_en2, in_rd_en2, read_done2, result_valid2;
    logic [11:0]     tr_addr2;
    logic [2:0]      in_addr2;
    logic [BUSW-1:0] td2, id2;
    logic [2:0]      type2, result_type2;

    logic            m_busy, m_tr_rd_en, m_in_rd_en, m_read_done, m_result_valid;
    logic [11:0]     m_tr_addr;
    logic [5:0]      m_in_addr;
    logic [BUSW-1:0] m_td, m_id;
    logic [2:0]      m_type, m_result_type;

    exp_t       sb_q[$];
    logic [2:0] res_q[$];
    exp_t       mon_e;
    logic [2:0] mon_r;

    int checks = 0;
    int errors = 0;
    int run_req = 0;
    int run_ack = 0;
    int rd_count = 0;
    int res_seen = 0;

    assign start1 = start & ~sel;
    assign start2 = start & sel;

    knn_load_sequencer #(.M(5), .N(10), .W(32), .MAX_ELEMENTS(16), .TYPE_W(3), .L(6), .AW(12)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1),
        .tr_addr(tr_addr1), .tr_rd_en(tr_rd_en1), .tr_rdata(tr_rdata),
        .in_addr(in_addr1), .in_rd_en(in_rd_en1), .in_rdata(in_rdata),
        .training_data(td1), .training_data_type(type1), .input_data(id1),
        .read_done(read_done1), .data_request(data_request), .done(done),
        .inference_done(inference_done), .inferred_type(inferred_type),
        .result_type(result_type1), .result_valid(result_valid1)
    );

    knn_load_sequencer #(.M(2), .N(4), .W(32), .MAX_ELEMENTS(16), .TYPE_W(3), .L(1), .AW(12)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2),
        .tr_addr(tr_addr2), .tr_rd_en(tr_rd_en2), .tr_rdata(tr_rdata),
        .in_addr(in_addr2), .in_rd_en(in_rd_en2), .in_rdata(in_rdata),
        .training_data(td2), .training_data_type(type2), .input_data(id2),
        .read_done(read_done2), .data_request(data_request), .done(done),
        .inference_done(inference_done), .inferred_type(inferred_type),
        .result_type(result_type2), .result_valid(result_valid2)
    );

    assign m_busy         = sel ? busy2 : busy1;
    assign m_tr_rd_en     = sel ? tr_rd_en2 : tr_rd_en1;
    assign m_in_rd_en     = sel ? in_rd_en2 : in_rd_en1;
    assign m_read_done    = sel ? read_done2 : read_done1;
    assign m_result_valid = sel ? result_valid2 : result_valid1;
    assign m_tr_addr      = sel ? tr_addr2 : tr_addr1;
    assign m_in_addr      = sel ? {3'b000, in_addr2} : in_addr1;
    assign m_td           = sel ? td2 : td1;
    assign m_id           = sel ? id2 : id1;
    assign m_type         = sel ? type2 : type1;
    assign m_result_type  = sel ? result_type2 : result_type1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2:0] lbl(int s);
        return 3'((s * 2 + 3) % 8);
    endfunction

    function automatic logic [31:0] tr_val(int a, int stride, int elems);
        if (a % stride == elems) return 32'h5550_0000 | 32'(lbl(a / stride));
        return 32'hA000_0000 | 32'(a);
    endfunction

    task automatic check(input string nm, input logic [BUSW-1:0] got, input logic [BUSW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic push_run(input logic cfg);
        int   elems, stride, nb, ns, ne;
        exp_t e;
        elems  = cfg ? 8 : 50;
        stride = elems + 1;
        nb     = (elems + 15) / 16;
        ns     = cfg ? 2 : 64;
        for (int s = 0; s < ns; s++) begin
            for (int b = 0; b < nb; b++) begin
                ne     = (b == nb - 1) ? elems - b * 16 : 16;
                e.addr = 12'(s * stride + b * 16);
                e.td   = '0;
                e.id   = '0;
                for (int j = 0; j < ne; j++) begin
                    e.td[j*32 +: 32] = tr_val(s * stride + b * 16 + j, stride, elems);
                    e.id[j*32 +: 32] = 32'hB000_0000 | 32'(b * 16 + j);
                end
                e.typ = (b == nb - 1) ? lbl(s) : ((s == 0) ? 3'd0 : lbl(s - 1));
                e.lat = (b == nb - 1) ? ne + 2 : ne + 1;
                e.trn = (b == nb - 1) ? ne + 1 : ne;
                e.inn = ne;
                sb_q.push_back(e);
            end
        end
        res_q.push_back(inferred_type);
    endtask

    // Synchronous memories: data for a read issued in cycle n appears during cycle n+1.
    initial begin
        bit tr_pv, in_pv;
        int tr_pa, in_pa;
        tr_pv = 1'b0; in_pv = 1'b0; tr_pa = 0; in_pa = 0;
        tr_rdata = 32'hDEAD_BEEF;
        in_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            tr_rdata = tr_pv ? tr_val(tr_pa, sel ? 9 : 51, sel ? 8 : 50) : 32'hDEAD_BEEF;
            in_rdata = in_pv ? (32'hB000_0000 | 32'(in_pa)) : 32'hDEAD_BEEF;
            tr_pv = m_tr_rd_en;
            tr_pa = int'(m_tr_addr);
            in_pv = m_in_rd_en;
            in_pa = int'(m_in_addr);
        end
    end

    // knn_system stand-in: request/done pulses after each read_done, plus corner cases.
    initial begin
        int req_cd, done_cd, inf_cd, spur_cd, stray_cd, rb, rs, nb, ns;
        req_cd = 0; done_cd = 0; inf_cd = 0; spur_cd = 0; stray_cd = 0; rb = 0; rs = 0;
        start = 1'b0; data_request = 1'b0; done = 1'b0; inference_done = 1'b0;
        forever begin
            @(negedge clk);
            start = 1'b0; data_request = 1'b0; done = 1'b0; inference_done = 1'b0;
            nb = sel ? 1 : 4;
            ns = sel ? 2 : 64;
            if (!rst) begin
                req_cd = 0; done_cd = 0; inf_cd = 0; spur_cd = 0; stray_cd = 0;
                rb = 0; rs = 0; rd_count = 0;
                continue;
            end
            if (run_req != run_ack) begin
                run_ack = run_req;
                start = 1'b1;
                rb = 0; rs = 0;
            end
            if (req_cd > 0)   begin req_cd--;   if (req_cd == 0)   data_request = 1'b1;   end
            if (done_cd > 0)  begin done_cd--;  if (done_cd == 0)  done = 1'b1;           end
            if (inf_cd > 0)   begin inf_cd--;   if (inf_cd == 0)   inference_done = 1'b1; end
            if (spur_cd > 0)  begin spur_cd--;  if (spur_cd == 0)  data_request = 1'b1;   end
            if (stray_cd > 0) begin stray_cd--; if (stray_cd == 0) start = 1'b1;          end
            if (m_read_done) begin
                rd_count++;
                if (rb == nb - 1) begin
                    done_cd = (!sel && rs == 3) ? 1 : 2;
                    if (!sel && rs == 5) req_cd = 2;
                    rb = 0;
                    rs++;
                    if (rs == ns) inf_cd = 5;
                end else begin
                    req_cd = (!sel && rs == 1 && rb == 0) ? 1 : 2;
                    if (!sel && rs == 2 && rb == 1) spur_cd = 8;
                    if (!sel && rs == 0 && rb == 1) stray_cd = 1;
                    rb++;
                end
            end
        end
    end

    // Monitor: pop expected burst on every read_done, expected result on result_valid.
    initial begin
        int cyc, f_start, trn, inn;
        logic [11:0] f_addr;
        bit prev_en;
        cyc = 0; f_start = 0; trn = 0; inn = 0; f_addr = '0; prev_en = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                sb_q.delete();
                res_q.delete();
                prev_en = 1'b0; trn = 0; inn = 0;
                continue;
            end
            if (m_tr_rd_en && !prev_en) begin
                f_start = cyc;
                f_addr  = m_tr_addr;
            end
            prev_en = m_tr_rd_en;
            trn += int'(m_tr_rd_en);
            inn += int'(m_in_rd_en);
            if (m_read_done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_read_done", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("first_tr_addr", BUSW'(f_addr), BUSW'(mon_e.addr));
                    check("training_data", m_td, mon_e.td);
                    check("input_data", m_id, mon_e.id);
                    check("training_data_type", BUSW'(m_type), BUSW'(mon_e.typ));
                    check("fetch_latency", BUSW'(cyc - f_start), BUSW'(mon_e.lat));
                    check("tr_read_count", BUSW'(trn), BUSW'(mon_e.trn));
                    check("in_read_count", BUSW'(inn), BUSW'(mon_e.inn));
                end
                trn = 0;
                inn = 0;
            end
            if (m_result_valid) begin
                if (res_q.size() == 0) begin
                    check("unexpected_result_valid", 1, 0);
                end else begin
                    mon_r = res_q.pop_front();
                    check("result_type", BUSW'(m_result_type), BUSW'(mon_r));
                    check("busy_at_result", BUSW'(m_busy), 0);
                end
                res_seen++;
            end
        end
    end

    initial begin
        int i;
        sel = 1'b0;
        inferred_type = 3'd2;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", BUSW'(busy1), 0);
        check("rst_read_done", BUSW'(read_done1), 0);
        check("rst_rd_en", BUSW'({tr_rd_en1, in_rd_en1}), 0);
        check("rst_tr_addr", BUSW'(tr_addr1), 0);
        check("rst_training_data", td1, 0);
        check("rst_input_data", id1, 0);
        check("rst_type", BUSW'(type1), 0);
        check("rst_result", BUSW'({result_valid1, result_type1}), 0);
        rst = 1'b1;
        @(negedge clk);

        // Run that gets aborted by reset during sample 10, burst 2.
        push_run(1'b0);
        run_req++;
        repeat (3) @(negedge clk);
        #1;
        check("busy_after_start", BUSW'(busy1), 1);
        for (i = 0; i < 5000 && !(rd_count == 42 && tr_rd_en1); i++) begin
            @(negedge clk);
            #1;
        end
        check("reach_sample10_burst2", BUSW'(rd_count == 42 && tr_rd_en1), 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_ctrl", BUSW'({busy1, read_done1, tr_rd_en1, in_rd_en1, result_valid1}), 0);
        check("abort_addr", BUSW'({tr_addr1, in_addr1}), 0);
        check("abort_training_data", td1, 0);
        check("abort_input_data", id1, 0);
        check("abort_types", BUSW'({type1, result_type1}), 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Full run: 256 bursts, result 2.
        push_run(1'b0);
        run_req++;
        for (i = 0; i < 20000 && res_seen < 1; i++) @(negedge clk);
        check("full_run_result_seen", BUSW'(res_seen), 1);
        repeat (2) @(negedge clk);
        #1;
        check("idle_busy", BUSW'(busy1), 0);
        check("result_valid_one_cycle", BUSW'(result_valid1), 0);
        check("read_done_total", BUSW'(rd_count), 256);
        check("bursts_left", BUSW'(sb_q.size()), 0);
        check("results_left", BUSW'(res_q.size()), 0);

        // Small configuration: 8 elements, one burst per sample.
        sel = 1'b1;
        inferred_type = 3'd6;
        @(negedge clk);
        push_run(1'b1);
        run_req++;
        for (i = 0; i < 2000 && res_seen < 2; i++) @(negedge clk);
        check("small_run_result_seen", BUSW'(res_seen), 2);
        repeat (2) @(negedge clk);
        #1;
        check("small_idle_busy", BUSW'(busy2), 0);
        check("small_bursts_left", BUSW'(sb_q.size()), 0);
        check("dut1_stays_idle", BUSW'(busy1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/knn_load_sequencer.md
Name: knn_load_sequencer

Overview:
- Fetches training samples and the query vector from two synchronous memories and streams them into knn_system in MAX_ELEMENTS-wide bursts.
- Runs the read_done / data_request / done handshake across all 2^L training samples, then captures the final inference result.
- Sits between the sample memories and knn_system.
- Replaces the testbench-driven load loop in the integrated design.

Parameters:
M, 5, matrix rows per vector
N, 10, matrix columns per vector
W, 32, element width in bits
MAX_ELEMENTS, 16, lanes per burst
TYPE_W, 3, class label width
L, 6, log2 of training sample count
AW, 12, training memory address width (must hold (1<<L)*(M*N+1))

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  one-cycle pulse; begins a full inference run
busy  out  1  high from accepting start until result_valid
tr_addr  out  AW  training memory address
tr_rd_en  out  1  training memory read enable
tr_rdata  in  W  training memory data, valid 1 cycle after tr_rd_en
in_addr  out  clog2(M*N)  input memory address (element index)
in_rd_en  out  1  input memory read enable
in_rdata  in  W  input memory data, valid 1 cycle after in_rd_en
training_data  out  W*MAX_ELEMENTS  burst lanes to knn_system; lane j at [W*(j+1)-1 -: W]
training_data_type  out  TYPE_W  label of the current sample
input_data  out  W*MAX_ELEMENTS  query burst lanes, same lane mapping
read_done  out  1  one-cycle pulse: burst on buses is valid
data_request  in  1  knn_system ready for next burst of same sample
done  in  1  knn_system finished current sample
inference_done  in  1  knn_system finished all samples
result_type  out  TYPE_W  inferred class of the last run
result_valid  out  1  one-cycle pulse when result_type updates

Behaviour:
- Memory layout:
  - Training element e of sample s is at tr_addr = s*(M*N+1)+e.
  - The label of sample s is at s*(M*N+1)+M*N, in bits [TYPE_W-1:0].
  - Input element e is at in_addr = e.
- Bursts per sample: NB = ceil(M*N/MAX_ELEMENTS).
  - Burst b carries elements b*MAX_ELEMENTS .. min((b+1)*MAX_ELEMENTS, M*N)-1 in lanes 0..E-1.
  - Unused lanes are driven to 0.
- Reset: all outputs 0, state IDLE, counters 0, sticky flags cleared.
  - Reset asserted mid-run aborts the run immediately.
  - No result_valid is produced for the aborted run.
- States:
  - IDLE: busy=0; start -> FETCH with sample=0, burst=0. start in any other state is ignored.
  - FETCH: zeroes both lane buffers on entry. Issues one tr/in read per cycle for E cycles, with tr_rd_en and in_rd_en together at the same element index. Each lane is captured the cycle after its read was issued. Last burst of a sample -> TYPE; otherwise -> DRAIN.
  - TYPE: issues the label read (in_rd_en low) -> DRAIN.
  - DRAIN: captures the final word (lane or label) -> SEND.
  - SEND: read_done=1 for exactly one cycle; sticky flags cleared. Not last burst -> WAIT_REQ; last burst -> WAIT_DONE.
  - WAIT_REQ: on req_flag, burst++ -> FETCH.
  - WAIT_DONE: on done_flag, burst=0. If sample == (1<<L)-1 -> WAIT_INF; else sample++ -> FETCH.
  - WAIT_INF: on inf_flag, latch result_type from knn_system inferred_type (input inferred_type TYPE_W, shared with result path) -> REPORT.
  - REPORT: result_valid=1 for one cycle, busy drops the same cycle -> IDLE.
- Handshake inputs:
  - data_request, done and inference_done are each latched into a sticky flag in any state after SEND.
  - This catches pulses arriving the cycle after read_done.
  - Flags clear in SEND and IDLE.
  - Simultaneous data_request and done in WAIT_DONE: done wins; the request is discarded.
- Bus stability:
  - training_data, input_data and training_data_type hold from SEND until the next FETCH entry.
  - training_data_type updates only at label capture.
- Latency: FETCH entry to read_done = E+1 cycles for a non-last burst and E+2 for the last burst.
- Counters: the sample counter is L+1 bits, so there is no wrap before the terminal compare. The burst counter is clog2(NB)+1 bits.

Test Plan:
- Defaults (50 elements, NB=4); start once; datapath model raises data_request 2 cycles after each read_done and done after the 4th -> exactly 4 read_done per sample, 256 total. Burst 3 carries lanes 0-1 only; lanes 2-15 are 0. tr_addr of the first read of sample 1 is 51.
- Memory holds label 3 at addr 50 and 5 at addr 101 -> training_data_type=3 at sample 0's last read_done and 5 at sample 1's.
- data_request pulsed the cycle right after read_done -> sequencer still advances (sticky flag). Pulsed during FETCH -> ignored.
- inference_done with inferred_type=2 after the 64th done -> one result_valid pulse with result_type=2. busy is low the same cycle, then idle.
- start pulsed during WAIT_REQ -> no restart; address sequence unchanged.
- rst driven low during sample 10 burst 2 -> all outputs 0 asynchronously. After release, start -> fetch restarts at tr_addr=0.
- M=2, N=4 (8 < MAX_ELEMENTS) -> NB=1. Each sample is a single burst with lanes 8-15 zero, and read_done comes E+2 = 10 cycles after FETCH entry.
